// File: rtl/frame_buffer_loader.sv
// Byte-stream to framebuffer loader: assembles 12-bit pixels from byte pairs
// and writes them to a simple dual-port RAM that the VGA stage reads.
module frame_buffer_loader #(
   parameter int ADDR_W = 11,
   parameter int PIX_W  = 12
) (
   input  logic              clk_100MHz,
   input  logic              reset,
   input  logic              frame_start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [PIX_W-1:0]  rd_data,
   output logic [ADDR_W-1:0] wr_addr,
   output logic              frame_done
);

   typedef enum logic [1:0] {HI, LO, WR} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [PIX_W-1:0]    pixel_q, pixel_d;
   logic                frame_done_q, frame_done_d;
   logic [PIX_W-1:0]    rd_data_q, rd_data_d;
   logic                mem_we;
   logic                accept;

   logic [PIX_W-1:0]    mem [0:(1<<ADDR_W)-1];

   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
         state_q      <= HI;
         wr_addr_q    <= '0;
         pixel_q      <= '0;
         frame_done_q <= 1'b0;
         rd_data_q    <= '0;
      end else begin
         state_q      <= state_d;
         wr_addr_q    <= wr_addr_d;
         pixel_q      <= pixel_d;
         frame_done_q <= frame_done_d;
         rd_data_q    <= rd_data_d;
      end
   end

   // Reset is folded in so upstream never sees ready while the block is held.
   assign in_ready = (state_q != WR) && !frame_start && !reset;
   assign accept   = in_valid && in_ready;

   always_comb begin
      state_d      = state_q;
      wr_addr_d    = wr_addr_q;
      pixel_d      = pixel_q;
      frame_done_d = 1'b0;
      mem_we       = 1'b0;

      if (frame_start) begin
         state_d   = HI;
         wr_addr_d = '0;
         pixel_d   = '0;
      end else begin
         unique case (state_q)
            HI: if (accept) begin
               pixel_d = {in_data, pixel_q[3:0]};
               state_d = LO;
            end
            LO: if (accept) begin
               pixel_d = {pixel_q[PIX_W-1:4], in_data[3:0]};
               state_d = WR;
            end
            WR: begin
               mem_we       = 1'b1;
               wr_addr_d    = wr_addr_q + ADDR_W'(1);
               frame_done_d = (wr_addr_q == '1);
               state_d      = HI;
            end
            default: state_d = HI;
         endcase
      end
   end

   always_comb begin
      rd_data_d = rd_data_q;
      if (rd_en) rd_data_d = mem[rd_addr];
   end

   // Memory has no reset so it maps onto block RAM; non-blocking write gives read-first.
   always_ff @(posedge clk_100MHz) begin
      if (mem_we) mem[wr_addr_q] <= pixel_q;
   end

   assign rd_data    = rd_data_q;
   assign wr_addr    = wr_addr_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_frame_buffer_loader.sv
// Directed bench for frame_buffer_loader: vector table plus hand sequences
// for frame_start, read-first, mid-pixel reset and a full frame stream.
module tb_frame_buffer_loader;

   localparam int ADDR_W = 11;
   localparam int PIX_W  = 12;

   logic              clk_100MHz = 1'b0;
   logic              reset = 1'b1;
   logic              frame_start = 1'b0;
   logic              in_valid = 1'b0;
   logic [7:0]        in_data = 8'h00;
   logic              in_ready;
   logic              rd_en = 1'b0;
   logic [ADDR_W-1:0] rd_addr = '0;
   logic [PIX_W-1:0]  rd_data;
   logic [ADDR_W-1:0] wr_addr;
   logic              frame_done;

   int n_chk  = 0;
   int n_fail = 0;

   frame_buffer_loader #(.ADDR_W(ADDR_W), .PIX_W(PIX_W)) dut (
      .clk_100MHz (clk_100MHz),
      .reset      (reset),
      .frame_start(frame_start),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .rd_en      (rd_en),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .wr_addr    (wr_addr),
      .frame_done (frame_done)
   );

   always #5 clk_100MHz = ~clk_100MHz;

   typedef struct {
      logic              fs;
      logic              v;
      logic [7:0]        d;
      logic              re;
      logic [ADDR_W-1:0] ra;
      logic              rdy;
      logic [ADDR_W-1:0] wa;
      logic [PIX_W-1:0]  rd;
      logic              fd;
   } vec_t;

   vec_t tbl [10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One clock: drive at negedge, sample ready before the edge, return 1ns after it.
   task automatic cyc(input logic fs, input logic v, input logic [7:0] d,
                      input logic re, input logic [ADDR_W-1:0] ra, output logic rdy);
      @(negedge clk_100MHz);
      frame_start = fs;
      in_valid    = v;
      in_data     = d;
      rd_en       = re;
      rd_addr     = ra;
      #1 rdy = in_ready;
      @(posedge clk_100MHz);
      #1;
   endtask

   task automatic write_pixel(input logic [PIX_W-1:0] p);
      logic r;
      cyc(1'b0, 1'b1, p[11:4], 1'b0, '0, r);
      cyc(1'b0, 1'b1, {4'hE, p[3:0]}, 1'b0, '0, r);
      cyc(1'b0, 1'b0, 8'h00, 1'b0, '0, r);
   endtask

   task automatic read_chk(input string name, input logic [ADDR_W-1:0] a, input logic [PIX_W-1:0] exp);
      logic r;
      cyc(1'b0, 1'b0, 8'h00, 1'b1, a, r);
      chk(name, 32'(rd_data), 32'(exp));
   endtask

   initial begin
      logic r;
      int   idx;
      int   cycles;
      int   pulses;
      logic [7:0] b;
      logic [PIX_W-1:0] p;

      tbl[0] = '{1'b0, 1'b1, 8'hAB, 1'b0, 11'd0, 1'b1, 11'd0, 12'h000, 1'b0};
      tbl[1] = '{1'b0, 1'b1, 8'hFC, 1'b0, 11'd0, 1'b1, 11'd0, 12'h000, 1'b0};
      tbl[2] = '{1'b0, 1'b1, 8'h00, 1'b0, 11'd0, 1'b0, 11'd1, 12'h000, 1'b0};
      tbl[3] = '{1'b0, 1'b0, 8'h00, 1'b1, 11'd0, 1'b1, 11'd1, 12'hABC, 1'b0};
      tbl[4] = '{1'b0, 1'b1, 8'h12, 1'b0, 11'd0, 1'b1, 11'd1, 12'hABC, 1'b0};
      tbl[5] = '{1'b0, 1'b0, 8'h99, 1'b0, 11'd3, 1'b1, 11'd1, 12'hABC, 1'b0};
      tbl[6] = '{1'b0, 1'b1, 8'hF3, 1'b0, 11'd5, 1'b1, 11'd1, 12'hABC, 1'b0};
      tbl[7] = '{1'b0, 1'b0, 8'h00, 1'b0, 11'd7, 1'b0, 11'd2, 12'hABC, 1'b0};
      tbl[8] = '{1'b0, 1'b0, 8'h00, 1'b1, 11'd1, 1'b1, 11'd2, 12'h123, 1'b0};
      tbl[9] = '{1'b0, 1'b0, 8'h00, 1'b0, 11'd0, 1'b1, 11'd2, 12'h123, 1'b0};

      // Reset state
      repeat (3) @(posedge clk_100MHz);
      @(negedge clk_100MHz);
      chk("reset_in_ready", 32'(in_ready), 32'd0);
      chk("reset_wr_addr", 32'(wr_addr), 32'd0);
      chk("reset_rd_data", 32'(rd_data), 32'd0);
      chk("reset_frame_done", 32'(frame_done), 32'd0);
      reset = 1'b0;
      #1 chk("release_in_ready", 32'(in_ready), 32'd1);

      // Table vectors: basic pixel, read latency, valid gaps, rd_en hold
      for (int i = 0; i < 10; i++) begin
         cyc(tbl[i].fs, tbl[i].v, tbl[i].d, tbl[i].re, tbl[i].ra, r);
         chk($sformatf("vec%0d_in_ready", i), 32'(r), 32'(tbl[i].rdy));
         chk($sformatf("vec%0d_wr_addr", i), 32'(wr_addr), 32'(tbl[i].wa));
         chk($sformatf("vec%0d_rd_data", i), 32'(rd_data), 32'(tbl[i].rd));
         chk($sformatf("vec%0d_frame_done", i), 32'(frame_done), 32'(tbl[i].fd));
      end

      // frame_start mid-pixel drops the partial pixel and the byte presented with it
      cyc(1'b0, 1'b1, 8'h12, 1'b0, '0, r);
      cyc(1'b1, 1'b1, 8'h34, 1'b0, '0, r);
      chk("fs_in_ready", 32'(r), 32'd0);
      chk("fs_wr_addr", 32'(wr_addr), 32'd0);
      write_pixel(12'h567);
      chk("fs_after_wr_addr", 32'(wr_addr), 32'd1);
      read_chk("fs_mem0", 11'd0, 12'h567);

      // frame_start during the WR cycle suppresses that write
      cyc(1'b0, 1'b1, 8'hAA, 1'b0, '0, r);
      cyc(1'b0, 1'b1, 8'h0B, 1'b0, '0, r);
      cyc(1'b1, 1'b0, 8'h00, 1'b0, '0, r);
      chk("fs_wr_wr_addr", 32'(wr_addr), 32'd0);
      read_chk("fs_wr_mem1_kept", 11'd1, 12'h123);

      // Read-first on a same-address collision
      cyc(1'b1, 1'b0, 8'h00, 1'b0, '0, r);
      for (int i = 0; i < 5; i++) write_pixel(12'(12'h100 + i));
      write_pixel(12'h111);
      cyc(1'b1, 1'b0, 8'h00, 1'b0, '0, r);
      for (int i = 0; i < 5; i++) write_pixel(12'(12'h100 + i));
      cyc(1'b0, 1'b1, 8'h22, 1'b0, '0, r);
      cyc(1'b0, 1'b1, 8'h02, 1'b0, '0, r);
      cyc(1'b0, 1'b0, 8'h00, 1'b1, 11'd5, r);
      chk("collide_old", 32'(rd_data), 32'h111);
      chk("collide_wr_addr", 32'(wr_addr), 32'd6);
      read_chk("collide_new", 11'd5, 12'h222);

      // Reset between high and low byte
      cyc(1'b0, 1'b1, 8'h77, 1'b0, '0, r);
      @(negedge clk_100MHz);
      in_valid = 1'b0;
      #2 reset = 1'b1;
      #1;
      chk("midreset_wr_addr", 32'(wr_addr), 32'd0);
      chk("midreset_rd_data", 32'(rd_data), 32'd0);
      chk("midreset_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk_100MHz);
      reset = 1'b0;
      read_chk("midreset_no_write", 11'd0, 12'h100);
      write_pixel(12'h3CD);
      chk("midreset_after_wr_addr", 32'(wr_addr), 32'd1);
      read_chk("midreset_mem0", 11'd0, 12'h3CD);

      // Full frame with in_valid held high: 4096 bytes, one pixel per 3 cycles
      cyc(1'b1, 1'b0, 8'h00, 1'b0, '0, r);
      idx = 0; cycles = 0; pulses = 0;
      while (idx < 4096 && cycles < 10000) begin
         p = 12'(idx >> 1);
         b = idx[0] ? {4'hA, p[3:0]} : p[11:4];
         cyc(1'b0, 1'b1, b, 1'b0, '0, r);
         if (r) idx++;
         if (frame_done) pulses++;
         cycles++;
      end
      chk("stream_bytes_accepted", 32'(idx), 32'd4096);
      cyc(1'b0, 1'b0, 8'h00, 1'b0, '0, r);
      cycles++;
      chk("stream_cycles", 32'(cycles), 32'd6144);
      chk("stream_early_pulses", 32'(pulses), 32'd0);
      chk("stream_frame_done", 32'(frame_done), 32'd1);
      chk("stream_wr_addr_wrap", 32'(wr_addr), 32'd0);
      cyc(1'b0, 1'b0, 8'h00, 1'b0, '0, r);
      chk("stream_frame_done_drop", 32'(frame_done), 32'd0);
      for (int a = 0; a < 2048; a++)
         read_chk($sformatf("readback_%0d", a), 11'(a), 12'(a));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/frame_buffer_loader.md
FRAME_BUFFER_LOADER -- requirements
Module: frame_buffer_loader

Interface
REQ-001 Parameter ADDR_W, default 11, SHALL set framebuffer address width (depth 2**ADDR_W; 2048 = 64x32 tiles).
REQ-002 Parameter PIX_W, default 12, SHALL set stored pixel width ({R[3:0],G[3:0],B[3:0]}).
REQ-003 clk_100MHz  input  1  system clock; all logic rising-edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 frame_start  input  1  synchronous pulse; restarts loading at address 0.
REQ-006 in_valid  input  1  upstream byte valid.
REQ-007 in_data  input  8  upstream byte.
REQ-008 in_ready  output  1  block accepts byte this cycle.
REQ-009 rd_en  input  1  read enable from VGA pixel stage (driven by video_on).
REQ-010 rd_addr  input  ADDR_W  read address ({y_tile,x_tile}, y_tile*64 + x_tile).
REQ-011 rd_data  output  PIX_W  registered read pixel.
REQ-012 wr_addr  output  ADDR_W  next write address.
REQ-013 frame_done  output  1  one-cycle pulse after last pixel of a frame written.

Function
REQ-014 Byte transfer SHALL occur on a rising edge with in_valid=1 and in_ready=1.
REQ-015 FSM states SHALL be HI (await high byte), LO (await low byte), WR (write cycle).
REQ-016 HI: accepted byte SHALL be latched as pixel[11:4]; next state LO.
REQ-017 LO: accepted byte bits [3:0] SHALL be latched as pixel[3:0], bits [7:4] ignored; next state WR.
REQ-018 WR: assembled pixel SHALL be written to mem[wr_addr]; wr_addr SHALL increment by 1; next state HI; lasts exactly one cycle.
REQ-019 in_ready SHALL be 1 in HI and LO, 0 in WR, and 0 in any cycle frame_start=1.
REQ-020 wr_addr SHALL wrap from 2**ADDR_W-1 to 0; the WR cycle writing address 2**ADDR_W-1 SHALL assert frame_done on the following cycle for exactly one cycle.
REQ-021 frame_start=1 SHALL, next edge, force state HI and wr_addr 0, discard any partial pixel, and drop any byte presented that cycle; it SHALL take priority over a WR in progress (that write suppressed).
REQ-022 Read port SHALL be independent of write port: rd_en=1 at edge N -> rd_data = mem[rd_addr] after edge N (1-cycle latency).
REQ-023 rd_en=0 SHALL hold rd_data at its previous value.
REQ-024 Same-address read and write in one cycle SHALL return the old (pre-write) contents (read-first).
REQ-025 Memory SHALL be inferable as a simple dual-port block RAM; contents not initialised and not cleared by reset.
REQ-026 Pixel throughput SHALL be one pixel per 3 cycles with in_valid held high.

Reset
REQ-027 reset=1 SHALL asynchronously force state HI, wr_addr 0, pixel latch 0, rd_data 0, frame_done 0; in_ready SHALL be 0 while reset asserted and 1 first cycle after release.
REQ-028 Reset asserted mid-pixel SHALL discard the partial pixel; no memory write occurs for it.

Verification
REQ-029 Reset, then bytes 0xAB,0xFC with in_valid=1 -> in_ready 1,1,0; mem[0]=0xABC; wr_addr=1; rd_en=1,rd_addr=0 -> rd_data=0xABC next cycle.
REQ-030 Stream 4096 bytes (2048 pixels, value = index[11:0]) -> frame_done single pulse after 2048th write; wr_addr=0; read-back of all 2048 addresses matches.
REQ-031 Send byte 0x12, assert frame_start with in_valid=1, in_data=0x34, then 0x56,0x07 -> mem[0]=0x567, 0x34 dropped, wr_addr=1.
REQ-032 mem[5]=0x111; write 0x222 to addr 5 while rd_en=1, rd_addr=5 same cycle -> rd_data=0x111; next read -> 0x222.
REQ-033 rd_en=0 with rd_addr changing -> rd_data unchanged; in_valid gaps between bytes -> state held, correct pixel assembled.
REQ-034 Assert reset between high and low byte -> wr_addr 0, no write, rd_data 0; next two bytes write mem[0].
